// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and FSM encoding for the register-file arbiter
package rf_arb_pkg;
    localparam int D_SIZE = 31;
    localparam int A_W = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if: requester handshake plus register-file bus signals of the arbiter
interface rf_arbiter_if #(
    parameter int N_REQ = 2
) ();
    import rf_arb_pkg::*;
    logic [N_REQ-1:0] req, we, gnt, done;
    logic [N_REQ*A_W-1:0] addr;
    logic [N_REQ*(D_SIZE+1)-1:0] wdata;
    logic [D_SIZE:0] rdata, rf_wdata, rf_rdata;
    logic [A_W-1:0] rf_addr;
    logic rf_rw, rf_drive;
    modport slave (
        input  req, we, addr, wdata, rf_rdata,
        output gnt, done, rdata, rf_addr, rf_rw, rf_drive, rf_wdata
    );
    modport master (
        output req, we, addr, wdata, rf_rdata,
        input  gnt, done, rdata, rf_addr, rf_rw, rf_drive, rf_wdata
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
    parameter int N = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // scan farthest-first so the closest request to ptr overwrites the rest
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = PW'(j);
                any = 1'b1;
            end
        end
        oh = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: round-robin sharing of the negedge-clocked register file among N_REQ requesters
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rf_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int DW = D_SIZE + 1;
    state_e state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick_idx;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, pick_oh;
    logic pick_any;
    logic [DW-1:0] rdata_q, rdata_d, rf_wdata_q, rf_wdata_d;
    logic [A_W-1:0] rf_addr_q, rf_addr_d;
    logic rf_rw_q, rf_rw_d;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .oh  (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    // the ACCESS output registers double as the latched request
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        win_d = win_q;
        gnt_d = '0;
        done_d = '0;
        rdata_d = rdata_q;
        rf_addr_d = rf_addr_q;
        rf_rw_d = 1'b0;
        rf_wdata_d = rf_wdata_q;
        if (state_q == ACCESS) begin
            state_d = RESP;
            done_d = N_REQ'(1) << win_q;
            rdata_d = rf_rw_q ? rdata_q : bus.rf_rdata;
        end else if (pick_any) begin
            state_d = ACCESS;
            ptr_d = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
            win_d = pick_idx;
            gnt_d = pick_oh;
            rf_addr_d = bus.addr[int'(pick_idx)*A_W +: A_W];
            rf_rw_d = bus.we[pick_idx];
            rf_wdata_d = bus.wdata[int'(pick_idx)*DW +: DW];
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            win_q <= '0;
            gnt_q <= '0;
            done_q <= '0;
            rdata_q <= '0;
            rf_addr_q <= '0;
            rf_rw_q <= 1'b0;
            rf_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            win_q <= win_d;
            gnt_q <= gnt_d;
            done_q <= done_d;
            rdata_q <= rdata_d;
            rf_addr_q <= rf_addr_d;
            rf_rw_q <= rf_rw_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.done = done_q;
    assign bus.rdata = rdata_q;
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_rw = rf_rw_q;
    assign bus.rf_drive = rf_rw_q;
    assign bus.rf_wdata = rf_wdata_q;
endmodule
